line_clear_scan: RTL and testbench

- Board clean-up stage directly downstream of the piece-to-RAM write. It runs after a landed piece has been committed to the board RAM and before the board is redrawn.
- Scans the board RAM from the bottom row to the top row. Every full row is removed by shifting all rows above it down one row, and the top row is then cleared.
- Reports the number of rows removed and pulses complete so the controller can advance to the redraw state.

---
 rtl/line_clear_scan.sv | 145 ++++++++++++++
 tb/tb_line_clear_scan.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_clear_scan.sv
// line_clear_scan: removes full rows from the board RAM, scanning bottom to top,
// dropping every row above a removed row by one and clearing the top row.
`default_nettype none

module line_clear_scan #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] ram_Q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              complete,
  output logic [2:0]        lines_cleared
);

  localparam int ROW_W = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
  localparam int COL_W = (BOARD_W > 1) ? $clog2(BOARD_W) : 1;
  localparam int AW1   = ADDR_W + 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BOARD_H - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(BOARD_W - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN_RD   = 3'd1,
    SCAN_CHK  = 3'd2,
    SHIFT_RD  = 3'd3,
    SHIFT_WR  = 3'd4,
    CLEAR_TOP = 3'd5,
    DONE      = 3'd6,
    HOLD      = 3'd7
  } state_t;

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] dst;
  logic [COL_W-1:0] col;

  // Address math is done one bit wider than the RAM port, then truncated.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
    return ADDR_W'(AW1'(r) * AW1'(BOARD_W) + AW1'(c));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      row           <= '0;
      dst           <= '0;
      col           <= '0;
      lines_cleared <= '0;
    end else if (!enable && state != IDLE) begin
      // Controller abandoned the run: the board is left as it stands.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            row           <= LAST_ROW;
            col           <= '0;
            lines_cleared <= '0;
            state         <= SCAN_RD;
          end
        end
        SCAN_RD: state <= SCAN_CHK;
        SCAN_CHK: begin
          if (ram_Q == '0) begin
            if (row == '0) begin
              state <= DONE;
            end else begin
              row   <= row - ROW_W'(1);
              col   <= '0;
              state <= SCAN_RD;
            end
          end else if (col == LAST_COL) begin
            dst   <= row;
            col   <= '0;
            state <= (row == '0) ? CLEAR_TOP : SHIFT_RD;
          end else begin
            col   <= col + COL_W'(1);
            state <= SCAN_RD;
          end
        end
        SHIFT_RD: state <= SHIFT_WR;
        SHIFT_WR: begin
          if (col != LAST_COL) begin
            col   <= col + COL_W'(1);
            state <= SHIFT_RD;
          end else if (dst > ROW_W'(1)) begin
            dst   <= dst - ROW_W'(1);
            col   <= '0;
            state <= SHIFT_RD;
          end else begin
            col   <= '0;
            state <= CLEAR_TOP;
          end
        end
        CLEAR_TOP: begin
          if (col == LAST_COL) begin
            col <= '0;
            if (lines_cleared != 3'd7) lines_cleared <= lines_cleared + 3'd1;
            // Row index kept: the row above has just dropped into it.
            state <= SCAN_RD;
          end else begin
            col <= col + COL_W'(1);
          end
        end
        DONE: state <= HOLD;
        HOLD: state <= HOLD;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM controls decode from state and counters only; ram_Q reaches ram_data alone.
  always_comb begin
    ram_addr = '0;
    ram_data = '0;
    ram_wren = 1'b0;
    complete = 1'b0;
    case (state)
      SCAN_RD:  ram_addr = cell_addr(row, col);
      SHIFT_RD: ram_addr = cell_addr(dst - ROW_W'(1), col);
      SHIFT_WR: begin
        ram_addr = cell_addr(dst, col);
        ram_data = ram_Q;
        ram_wren = 1'b1;
      end
      CLEAR_TOP: begin
        ram_addr = ADDR_W'(col);
        ram_wren = 1'b1;
      end
      DONE:    complete = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_line_clear_scan.sv
// tb_line_clear_scan: random and directed boards against a row-compaction model,
// with a scoreboard queue checked whenever the DUT pulses complete.
`timescale 1ns/1ps
`default_nettype none

module tb_line_clear_scan;

  localparam int W  = 10;
  localparam int H  = 20;
  localparam int N  = W * H;
  localparam int DW = 6;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] ram_Q;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic          complete;
  logic [2:0]    lines_cleared;

  always #5 clk = ~clk;

  line_clear_scan #(.BOARD_W(W), .BOARD_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ram_Q(ram_Q),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .complete(complete), .lines_cleared(lines_cleared)
  );

  // Board RAM: synchronous write, registered read (data one cycle after address).
  logic [DW-1:0] mem [256];
  logic [DW-1:0] stim [N];
  logic          load_all = 1'b0;

  always @(posedge clk) begin
    if (load_all) begin
      for (int i = 0; i < N; i++) mem[i] <= stim[i];
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
    end
    ram_Q <= mem[ram_addr];
  end

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  typedef struct packed {
    logic [N*DW-1:0] board;
    logic [2:0]      lines;
    logic [31:0]     cost;
    logic [31:0]     writes;
    logic [31:0]     start;
  } exp_t;

  exp_t sb[$];

  // Reference: final board = non-full rows packed to the bottom in order;
  // timing and write counts come from the per-row cycle costs.
  task automatic build_expect(output exp_t e);
    logic [DW-1:0] w [H][W];
    int  k, nfull, r, fz;
    bit  full, fin;
    e = '0;
    nfull = 0;
    k = H - 1;
    for (int rr = H - 1; rr >= 0; rr--) begin
      full = 1'b1;
      for (int cc = 0; cc < W; cc++) if (stim[rr*W+cc] == '0) full = 1'b0;
      if (full) nfull++;
      else begin
        for (int cc = 0; cc < W; cc++) e.board[(k*W+cc)*DW +: DW] = stim[rr*W+cc];
        k--;
      end
    end
    e.lines = (nfull > 7) ? 3'd7 : 3'(nfull);

    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++) w[rr][cc] = stim[rr*W+cc];
    r = H - 1;
    fin = 1'b0;
    while (!fin) begin
      fz = -1;
      for (int cc = W - 1; cc >= 0; cc--) if (w[r][cc] == '0) fz = cc;
      if (fz < 0) begin
        e.cost   += 32'(2*W + 2*W*r + W);
        e.writes += 32'(W*r + W);
        for (int rr = r; rr > 0; rr--)
          for (int cc = 0; cc < W; cc++) w[rr][cc] = w[rr-1][cc];
        for (int cc = 0; cc < W; cc++) w[0][cc] = '0;
      end else begin
        e.cost += 32'(2*(fz + 1));
        if (r == 0) fin = 1'b1;
        else r--;
      end
    end
  endtask

  // Monitor: pops one expectation per complete pulse.
  int unsigned wr_total = 0;
  int unsigned wr_base  = 0;
  int unsigned done_cnt = 0;
  logic        prev_en  = 1'b0;

  always @(negedge clk) begin : mon
    exp_t e;
    int   mism;
    if (enable && !prev_en) wr_base = wr_total;
    prev_en = enable;
    if (ram_wren) wr_total++;
    if (complete) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_complete", 1, 0);
      end else begin
        e = sb.pop_front();
        check("lines_cleared", lines_cleared, e.lines);
        check("latency", edge_cnt - e.start, e.cost);
        check("write_count", wr_total - wr_base, e.writes);
        mism = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== e.board[i*DW +: DW]) mism++;
        check("board_cells_wrong", mism, 0);
      end
    end
  end

  task automatic clear_stim();
    for (int i = 0; i < N; i++) stim[i] = '0;
  endtask

  task automatic fill_row(input int r, input logic [DW-1:0] colour);
    for (int c = 0; c < W; c++)
      stim[r*W+c] = (colour == '0) ? DW'($urandom_range(1, 63)) : colour;
  endtask

  task automatic load_board();
    @(posedge clk); #1 load_all = 1'b1;
    @(posedge clk); #1 load_all = 1'b0;
  endtask

  task automatic run_board(input string tag);
    exp_t e;
    int   waited;
    int unsigned base;
    build_expect(e);
    load_board();
    e.start = edge_cnt + 1;
    sb.push_back(e);
    base = done_cnt;
    enable = 1'b1;
    waited = 0;
    while (done_cnt == base && waited < 30000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (done_cnt == base) begin
      check({tag, "_timeout"}, 0, 1);
      sb.delete();
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
    end
    // Enable stays high a while: a second complete would be spurious.
    repeat (6) @(posedge clk);
    #1 enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic abort_run(input bit use_reset);
    int waited;
    clear_stim();
    fill_row(H-1, 6'h21);
    load_board();
    enable = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!ram_wren && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("abort_reached_write", ram_wren, 1);
    if (!use_reset) begin
      #2 enable = 1'b0;
      @(negedge clk);
      check("drop_wren", ram_wren, 0);
      check("drop_addr_idle", ram_addr, 0);
      check("drop_complete", complete, 0);
      check("drop_lines", lines_cleared, 0);
    end else begin
      #2 reset = 1'b1;
      #1;
      check("reset_wren_async", ram_wren, 0);
      check("reset_addr_idle", ram_addr, 0);
      check("reset_complete", complete, 0);
      @(negedge clk);
      check("reset_wren_held", ram_wren, 0);
      enable = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_wren", ram_wren, 0);
    check("rst_complete", complete, 0);
    check("rst_lines", lines_cleared, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data", ram_data, 0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Empty board: 20 rows x 2 cycles, complete seen at the 41st edge.
    clear_stim();
    run_board("empty");

    clear_stim();
    fill_row(19, 6'h05);
    stim[18*W] = 6'h12;
    run_board("single_row");

    clear_stim();
    for (int r = 16; r < 20; r++) fill_row(r, '0);
    run_board("four_rows");

    clear_stim();
    fill_row(19, '0);
    fill_row(17, '0);
    fill_row(18, 6'h0A);
    stim[18*W+3] = '0;
    run_board("split_rows");

    clear_stim();
    fill_row(0, 6'h3F);
    run_board("top_row");

    // More than seven full rows: count must saturate.
    clear_stim();
    for (int r = 8; r < 20; r++) fill_row(r, '0);
    stim[7*W+4] = 6'h2B;
    run_board("saturate");

    for (int n = 0; n < 8; n++) begin
      clear_stim();
      for (int r = 0; r < H; r++) begin
        if ($urandom_range(0, 99) < 35) fill_row(r, '0);
        else if ($urandom_range(0, 3) != 0) begin
          for (int c = 0; c < W; c++)
            stim[r*W+c] = ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom_range(1, 63));
          stim[r*W + $urandom_range(0, W-1)] = '0;
        end
      end
      run_board("random");
    end

    abort_run(1'b0);
    abort_run(1'b1);

    // Clean run after the aborts.
    clear_stim();
    fill_row(19, '0);
    fill_row(10, '0);
    stim[5*W+9] = 6'h07;
    run_board("after_abort");

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
